// File: rtl/axi_helper.sv
// Shared AXI-Lite types: response codes, subordinate FSM states, W/R payload structs.
// Payload structs are sized by SUB_DATA_W; the subordinate's DATA_W must equal it.
package axi_helper;

    localparam int SUB_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } sub_wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } sub_rstate_t;

    typedef struct packed {
        logic [SUB_DATA_W-1:0]   data;
        logic [SUB_DATA_W/8-1:0] strb;
    } WxDATA_t;

    typedef struct packed {
        logic [SUB_DATA_W-1:0] data;
        resp_t                 resp;
    } RxDATA_t;

endpackage

// File: rtl/sub_mem_array.sv
// DEPTH x DATA_W storage: byte-enabled write port, registered read port (1 cycle).
// Read and write to the same word on one edge returns the old word; storage is not reset.
module sub_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int MA_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [MA_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                rd_en,
    input  logic                rd_zero,
    input  logic [MA_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Sampling mem here before the write above lands gives read-before-write.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_zero ? '0 : mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_subordinate.sv
// AXI4-Lite subordinate over a byte-strobed word memory; B/R valid one cycle after the completing handshake.
// Registered, state-derived readies; B/R held stable under backpressure. SUB_ERR_RESP_EN: SLVERR for index >= DEPTH.
module axi_lite_subordinate
    import axi_helper::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int OFF   = $clog2(DATA_W/8);
    localparam int IDX_W = ADDR_W - OFF;
    localparam int MA_W  = $clog2(DEPTH);

    if (DATA_W != SUB_DATA_W) begin : g_width_check
        $error("DATA_W must equal axi_helper::SUB_DATA_W");
    end

    function automatic logic [MA_W-1:0] mem_addr(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] m;
        m = idx % IDX_W'(DEPTH);
        return m[MA_W-1:0];
    endfunction

    function automatic logic idx_err(input logic [IDX_W-1:0] idx);
`ifdef SUB_ERR_RESP_EN
        return idx >= IDX_W'(DEPTH);
`else
        logic unused_idx;
        unused_idx = ^idx;
        return 1'b0;
`endif
    endfunction

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

    // ---------------- write path ----------------
    sub_wstate_t      w_state_q, w_state_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    resp_t            bresp_q, bresp_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    WxDATA_t          wx_q, wx_d;

    logic             aw_hs, w_hs;
    logic             commit;
    logic [IDX_W-1:0] c_idx;
    WxDATA_t          c_wx;
    logic             c_err;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_idx_d  = aw_idx_q;
        wx_d      = wx_q;
        commit    = 1'b0;
        c_idx     = AWADDR[ADDR_W-1:OFF];
        c_wx      = '{data: WDATA, strb: WSTRB};
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    aw_idx_d  = AWADDR[ADDR_W-1:OFF];
                    w_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wx_d      = '{data: WDATA, strb: WSTRB};
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                c_idx = aw_idx_q;
                if (w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_HAVE_D: begin
                c_wx = wx_q;
                if (aw_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign c_err = idx_err(c_idx);

    always_comb begin
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = bresp_q;
        if (commit) begin
            bresp_d = c_err ? SLVERR : OKAY;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            aw_idx_q  <= '0;
            wx_q      <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_idx_q  <= aw_idx_d;
            wx_q      <= wx_d;
        end
    end

    // ---------------- read path ----------------
    sub_rstate_t      r_state_q, r_state_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    resp_t            rresp_q, rresp_d;
    logic             ar_hs;
    logic [IDX_W-1:0] ar_idx;
    logic             ar_err;
    logic [DATA_W-1:0] mem_rdata;
    RxDATA_t          rx;

    assign ar_hs  = ARVALID && arready_q;
    assign ar_idx = ARADDR[ADDR_W-1:OFF];
    assign ar_err = idx_err(ar_idx);

    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rresp_d   = ar_err ? SLVERR : OKAY;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    // Out-of-range writes are dropped here; the response still reports SLVERR.
    sub_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MA_W   (MA_W)
    ) u_mem (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .wr_en   (commit && !c_err),
        .wr_addr (mem_addr(c_idx)),
        .wr_data (c_wx.data),
        .wr_strb (c_wx.strb),
        .rd_en   (ar_hs),
        .rd_zero (ar_err),
        .rd_addr (mem_addr(ar_idx)),
        .rd_data (mem_rdata)
    );

    assign rx      = '{data: mem_rdata, resp: rresp_q};
    assign RDATA   = rx.data;
    assign RRESP   = rx.resp;
    assign RVALID  = rvalid_q;
    assign ARREADY = arready_q;
    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

endmodule
